alu_md_unit: RTL

//  Successor execute unit: all existing ALU ops combinationally, parametrised in WIDTH.

---
 rtl/alu_md_unit.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with an iterative multiply/divide engine.
// HI/LO are written one result per WIDTH-cycle mul/div run, or by mthi/mtlo.
module alu_md_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       alu_control,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] alu_out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] OP_SLL   = 5'h00;
    localparam logic [4:0] OP_SRL   = 5'h01;
    localparam logic [4:0] OP_SRA   = 5'h02;
    localparam logic [4:0] OP_SLLV  = 5'h03;
    localparam logic [4:0] OP_SRLV  = 5'h04;
    localparam logic [4:0] OP_SRAV  = 5'h05;
    localparam logic [4:0] OP_ADD   = 5'h06;
    localparam logic [4:0] OP_ADDU  = 5'h07;
    localparam logic [4:0] OP_SUB   = 5'h08;
    localparam logic [4:0] OP_SUBU  = 5'h09;
    localparam logic [4:0] OP_AND   = 5'h0A;
    localparam logic [4:0] OP_OR    = 5'h0B;
    localparam logic [4:0] OP_XOR   = 5'h0C;
    localparam logic [4:0] OP_NOR   = 5'h0D;
    localparam logic [4:0] OP_SLT   = 5'h0E;
    localparam logic [4:0] OP_SLTU  = 5'h0F;
    localparam logic [4:0] OP_LUI   = 5'h10;
    localparam logic [4:0] OP_MULT  = 5'h11;
    localparam logic [4:0] OP_MULTU = 5'h12;
    localparam logic [4:0] OP_DIV   = 5'h13;
    localparam logic [4:0] OP_DIVU  = 5'h14;
    localparam logic [4:0] OP_MFHI  = 5'h15;
    localparam logic [4:0] OP_MFLO  = 5'h16;
    localparam logic [4:0] OP_MTHI  = 5'h17;
    localparam logic [4:0] OP_MTLO  = 5'h18;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] oper_q, oper_d;
    logic             neg_q, neg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH-1:0] sum, diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH+1:0] div_tr;
    logic             div_ok;
    logic [WIDTH-1:0] div_hi_n, div_lo_n;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    function automatic logic [WIDTH-1:0] mag(
        input logic [WIDTH-1:0] v,
        input logic             s
    );
        return s ? (~v + 1'b1) : v;
    endfunction

    assign sum  = rs + rt;
    assign diff = rs - rt;

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Combinational ALU result and signed overflow flag
    always_comb begin
        alu_out  = '0;
        overflow = 1'b0;
        case (alu_control)
            OP_SLL:  alu_out = rt << shamt;
            OP_SRL:  alu_out = rt >> shamt;
            OP_SRA:  alu_out = $signed(rt) >>> shamt;
            OP_SLLV: alu_out = rt << rs[SHW-1:0];
            OP_SRLV: alu_out = rt >> rs[SHW-1:0];
            OP_SRAV: alu_out = $signed(rt) >>> rs[SHW-1:0];
            OP_ADD: begin
                alu_out  = sum;
                overflow = (rs[WIDTH-1] == rt[WIDTH-1])
                         & (sum[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_ADDU: alu_out = sum;
            OP_SUB: begin
                alu_out  = diff;
                overflow = (rs[WIDTH-1] != rt[WIDTH-1])
                         & (diff[WIDTH-1] != rs[WIDTH-1]);
            end
            OP_SUBU: alu_out = diff;
            OP_AND:  alu_out = rs & rt;
            OP_OR:   alu_out = rs | rt;
            OP_XOR:  alu_out = rs ^ rt;
            OP_NOR:  alu_out = ~(rs | rt);
            OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, $signed(rs) < $signed(rt)};
            OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, rs < rt};
            OP_LUI:  alu_out = {rt[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: alu_out = hi_q;
            OP_MFLO: alu_out = lo_q;
            default: alu_out = '0;
        endcase
    end

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, oper_q} : '0);
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        div_sh   = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_tr   = {1'b0, div_sh} - {2'b00, oper_q};
        div_ok   = ~div_tr[WIDTH+1];
        div_hi_n = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
        div_lo_n = {acc_lo_q[WIDTH-2:0], div_ok};
    end

    // Sign-corrected final results from the last iteration
    always_comb begin
        prod = {mul_hi_n, mul_lo_n};
        if (neg_q) begin
            prod = ~prod + 1'b1;
        end
        quo = neg_q ? (~div_lo_n + 1'b1) : div_lo_n;
        if (div0_q) begin
            quo = '1;
        end
        rem = rneg_q ? (~div_hi_n + 1'b1) : div_hi_n;
    end

    // Engine next-state: accept, iterate, and write HI/LO
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        oper_d   = oper_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    case (alu_control)
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_MUL;
                            cnt_d    = '0;
                            acc_hi_d = '0;
                            acc_lo_d = mag(rt, (alu_control == OP_MULT) & rt[WIDTH-1]);
                            oper_d   = mag(rs, (alu_control == OP_MULT) & rs[WIDTH-1]);
                            neg_d    = (alu_control == OP_MULT)
                                     & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            rneg_d   = 1'b0;
                            div0_d   = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_DIV;
                            cnt_d    = '0;
                            acc_hi_d = '0;
                            acc_lo_d = mag(rs, (alu_control == OP_DIV) & rs[WIDTH-1]);
                            oper_d   = mag(rt, (alu_control == OP_DIV) & rt[WIDTH-1]);
                            neg_d    = (alu_control == OP_DIV)
                                     & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            rneg_d   = (alu_control == OP_DIV) & rs[WIDTH-1];
                            div0_d   = (rt == '0);
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_d = mul_hi_n;
                acc_lo_d = mul_lo_n;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hi_d    = prod[2*WIDTH-1:WIDTH];
                    lo_d    = prod[WIDTH-1:0];
                end
            end
            S_DIV: begin
                acc_hi_d = div_hi_n;
                acc_lo_d = div_lo_n;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hi_d    = rem;
                    lo_d    = quo;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and HI/LO registers; reset abandons any running operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            oper_q   <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            oper_q   <= oper_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
